// File: rtl/sync_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module  : sync_frame_serializer
// Brief   : Serializes 16-bit payload words into frames of SYNC + payload + gap.
// Revision: 1.0 - initial release
// ============================================================================
module sync_frame_serializer #(
    parameter logic [15:0] SYNC_WORD = 16'hAFAF,
    parameter int          GAP_BITS  = 2,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam logic       c_GAP_EN   = (GAP_BITS > 0);
    localparam logic [3:0] c_GAP_LOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_dec;
    logic [15:0] r_payload;
    logic        r_data;
    logic        w_data_nxt;
    logic        r_done;
    logic [15:0] r_frames;
    logic        w_accept;
    logic        w_load;
    logic        w_frame_end;

    assign word_ready  = (r_state == S_IDLE) && tx_enable && !reset;
    assign w_accept    = word_valid && word_ready;
    assign w_cnt_dec   = r_cnt - 4'd1;
    assign data        = r_data;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign frames_sent = r_frames;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_SYNC;
            S_SYNC:    if (r_cnt == 4'd0) w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (r_cnt == 4'd0) w_state_nxt = c_GAP_EN ? S_GAP : S_IDLE;
            S_GAP:     if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next line bit, bit counter and frame-completion strobe for the coming edge.
    always_comb begin
        w_data_nxt  = IDLE_BIT;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_data_nxt = SYNC_WORD[15];
                    w_cnt_nxt  = 4'd15;
                    w_load     = 1'b1;
                end
            end
            S_SYNC: begin
                if (r_cnt == 4'd0) begin
                    w_data_nxt = r_payload[15];
                    w_cnt_nxt  = 4'd15;
                end else begin
                    w_data_nxt = SYNC_WORD[w_cnt_dec];
                    w_cnt_nxt  = w_cnt_dec;
                end
            end
            S_PAYLOAD: begin
                if (r_cnt == 4'd0) begin
                    w_cnt_nxt   = c_GAP_LOAD;
                    w_frame_end = !c_GAP_EN;
                end else begin
                    w_data_nxt = r_payload[w_cnt_dec];
                    w_cnt_nxt  = w_cnt_dec;
                end
            end
            S_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data    <= IDLE_BIT;
            r_cnt     <= 4'd0;
            r_payload <= 16'd0;
            r_done    <= 1'b0;
            r_frames  <= 16'd0;
        end else begin
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_frame_end;
            if (w_load) begin
                r_payload <= word_in;
            end
            if (w_frame_end) begin
                r_frames <= r_frames + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_frame_serializer
// Brief   : Randomized bench for GAP_BITS=2 and GAP_BITS=0 builds vs. a frame model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sync_frame_serializer;

    localparam logic [15:0] c_SYNC = 16'hAFAF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b0;
    logic [15:0] word_in = 16'd0;
    logic        word_valid = 1'b0;

    logic        w_ready [2];
    logic        w_data  [2];
    logic        w_busy  [2];
    logic        w_done  [2];
    logic [15:0] w_frames[2];

    int n_vec = 0;
    int n_err = 0;

    // Per-build frame model: index 0 is GAP_BITS=2, index 1 is GAP_BITS=0.
    int          m_gap  [2] = '{2, 0};
    bit          m_in   [2];
    int          m_pos  [2];
    logic [31:0] m_fr   [2];
    bit          m_done [2];
    logic [15:0] m_cnt  [2];

    always #5 clock = ~clock;

    sync_frame_serializer #(.SYNC_WORD(c_SYNC), .GAP_BITS(2), .IDLE_BIT(1'b0)) u_dut_g2 (
        .clock      (clock),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (w_ready[0]),
        .data       (w_data[0]),
        .busy       (w_busy[0]),
        .frame_done (w_done[0]),
        .frames_sent(w_frames[0])
    );

    sync_frame_serializer #(.SYNC_WORD(c_SYNC), .GAP_BITS(0), .IDLE_BIT(1'b0)) u_dut_g0 (
        .clock      (clock),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (w_ready[1]),
        .data       (w_data[1]),
        .busy       (w_busy[1]),
        .frame_done (w_done[1]),
        .frames_sent(w_frames[1])
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, advance the model at the edge.
    task automatic step(input bit rst, input bit en, input bit vld, input logic [15:0] w);
        bit acc[2];
        bit exp_bit;
        @(negedge clock);
        reset      = rst;
        tx_enable  = en;
        word_valid = vld;
        word_in    = w;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_bit = m_in[k] && (m_pos[k] < 32) ? m_fr[k][31 - m_pos[k]] : 1'b0;
            check($sformatf("g%0d.data", m_gap[k]),  16'(w_data[k]),  16'(exp_bit));
            check($sformatf("g%0d.busy", m_gap[k]),  16'(w_busy[k]),  16'(m_in[k]));
            check($sformatf("g%0d.ready", m_gap[k]), 16'(w_ready[k]), 16'(!m_in[k] && en && !rst));
            check($sformatf("g%0d.done", m_gap[k]),  16'(w_done[k]),  16'(m_done[k]));
            check($sformatf("g%0d.frames", m_gap[k]), w_frames[k],    m_cnt[k]);
            acc[k] = !m_in[k] && en && !rst && vld;
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_in[k]   = 1'b0;
                m_done[k] = 1'b0;
                m_cnt[k]  = 16'd0;
            end else if (m_in[k]) begin
                if (m_pos[k] == 32 + m_gap[k] - 1) begin
                    m_in[k]   = 1'b0;
                    m_done[k] = 1'b1;
                    m_cnt[k]  = m_cnt[k] + 16'd1;
                end else begin
                    m_pos[k]++;
                end
            end else begin
                m_done[k] = 1'b0;
                if (acc[k]) begin
                    m_in[k]  = 1'b1;
                    m_pos[k] = 0;
                    m_fr[k]  = {c_SYNC, w};
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_in[k]   = 1'b0;
            m_pos[k]  = 0;
            m_fr[k]   = 32'd0;
            m_done[k] = 1'b0;
            m_cnt[k]  = 16'd0;
        end
        repeat (2) @(posedge clock);

        // Reset held, then a long idle stretch.
        step(1'b1, 1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'h5555);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 16'd0);

        // Single frame 0x1234.
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 16'hDEAD);

        // Back-to-back words with valid held high.
        for (int n = 1; n <= 3; n++) begin
            for (int i = 0; i < 35; i++) step(1'b0, 1'b1, 1'b1, 16'(n));
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 16'd0);

        // Reset during payload bit 5 of 0xFFFF.
        step(1'b0, 1'b1, 1'b1, 16'hFFFF);
        for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 16'd0);

        // Enable gating, then enable dropped mid-frame with valid still high.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 16'hAFAF);
        step(1'b0, 1'b1, 1'b1, 16'hAFAF);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, 16'h0F0F);

        // Randomized traffic, including sync-equal payloads and rare resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? c_SYNC : 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
